// File: rtl/fxp_accum_seq.sv
// Frame accumulator sequencer: drives an external add/sub unit and registers a
// saturating running sum, presenting the frame result through valid/ready.
module fxp_accum_seq #(
  parameter int N   = 8,
  parameter int LEN = 4,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_ccn,
  output logic         out_ccz,
  output logic         out_ccc,
  output logic         out_ovf,
  output logic [N-1:0] add_x,
  output logic [N-1:0] add_y,
  output logic         add_sub,
  input  logic [N-1:0] add_result,
  input  logic         add_ccn,
  input  logic         add_ccz,
  input  logic         add_ccv,
  input  logic         add_ccc
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
  localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  state_e             state_q;
  logic [N-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               n_q, n_d;
  logic               z_q, z_d;
  logic               c_q;
  logic               ovf_q;

  // Saturation select: an overflowed result with MSB set came from two positives.
  always_comb begin
    acc_d = add_result;
    n_d   = add_ccn;
    z_d   = add_ccz;
    if (SAT && add_ccv) begin
      if (add_result[N-1]) begin
        acc_d = MAX_POS;
        n_d   = 1'b0;
        z_d   = 1'b0;
      end else begin
        acc_d = MIN_NEG;
        n_d   = 1'b1;
        z_d   = 1'b0;
      end
    end else begin
      acc_d = add_result;
      n_d   = add_ccn;
      z_d   = add_ccz;
    end
  end

  // Frame FSM with accumulator, operand counter and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            acc_q <= acc_d;
            n_q   <= n_d;
            z_q   <= z_d;
            c_q   <= add_ccc;
            ovf_q <= ovf_q | add_ccv;
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            acc_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= ST_ACC;
          end
        end
        default: begin
          state_q <= ST_ACC;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = acc_q;
  assign out_ccn   = n_q;
  assign out_ccz   = z_q;
  assign out_ccc   = c_q;
  assign out_ovf   = ovf_q;

  assign add_x   = acc_q;
  assign add_y   = in_data;
  assign add_sub = in_sub;

endmodule

// File: tb/tb_fxp_accum_seq.sv
// Directed bench for fxp_accum_seq: two instances (SAT=1 and SAT=0) share stimulus,
// each attached to a behavioural 8-bit add/sub unit.
module tb_fxp_accum_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sub;
  logic       out_ready;

  logic       s1_in_ready, s1_out_valid, s1_ccn, s1_ccz, s1_ccc, s1_ovf;
  logic [7:0] s1_out_data, s1_ax, s1_ay, s1_res;
  logic       s1_as, s1_an, s1_az, s1_av, s1_ac;

  logic       s0_in_ready, s0_out_valid, s0_ccn, s0_ccz, s0_ccc, s0_ovf;
  logic [7:0] s0_out_data, s0_ax, s0_ay, s0_res;
  logic       s0_as, s0_an, s0_az, s0_av, s0_ac;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Behavioural adder: returns {v, c, z, n, result}; subtract is x + ~y + 1.
  function automatic logic [11:0] addf(input logic [7:0] x, input logic [7:0] y, input logic sub);
    logic [7:0] yy;
    logic [8:0] s;
    logic       v;
    yy = sub ? ~y : y;
    s  = {1'b0, x} + {1'b0, yy} + {8'd0, sub};
    v  = (x[7] == yy[7]) && (s[7] != x[7]);
    return {v, s[8], (s[7:0] == 8'd0), s[7], s[7:0]};
  endfunction

  always_comb {s1_av, s1_ac, s1_az, s1_an, s1_res} = addf(s1_ax, s1_ay, s1_as);
  always_comb {s0_av, s0_ac, s0_az, s0_an, s0_res} = addf(s0_ax, s0_ay, s0_as);

  fxp_accum_seq #(.N(8), .LEN(4), .SAT(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s1_in_ready),
    .in_data(in_data), .in_sub(in_sub), .out_valid(s1_out_valid), .out_ready(out_ready),
    .out_data(s1_out_data), .out_ccn(s1_ccn), .out_ccz(s1_ccz), .out_ccc(s1_ccc),
    .out_ovf(s1_ovf), .add_x(s1_ax), .add_y(s1_ay), .add_sub(s1_as),
    .add_result(s1_res), .add_ccn(s1_an), .add_ccz(s1_az), .add_ccv(s1_av), .add_ccc(s1_ac)
  );

  fxp_accum_seq #(.N(8), .LEN(4), .SAT(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s0_in_ready),
    .in_data(in_data), .in_sub(in_sub), .out_valid(s0_out_valid), .out_ready(out_ready),
    .out_data(s0_out_data), .out_ccn(s0_ccn), .out_ccz(s0_ccz), .out_ccc(s0_ccc),
    .out_ovf(s0_ovf), .add_x(s0_ax), .add_y(s0_ay), .add_sub(s0_as),
    .add_result(s0_res), .add_ccn(s0_an), .add_ccz(s0_az), .add_ccv(s0_av), .add_ccc(s0_ac)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic sub, input logic [7:0] d);
    in_valid = 1'b1;
    in_sub   = sub;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_sub   = 1'b0;
    in_data  = 8'd0;
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] d, input logic n,
                           input logic z, input logic c, input logic ovf);
    chk({tag, ".out_valid"}, {31'd0, s1_out_valid}, 32'd1);
    chk({tag, ".in_ready"},  {31'd0, s1_in_ready},  32'd0);
    chk({tag, ".data"},      {24'd0, s1_out_data},  {24'd0, d});
    chk({tag, ".n"},         {31'd0, s1_ccn},       {31'd0, n});
    chk({tag, ".z"},         {31'd0, s1_ccz},       {31'd0, z});
    chk({tag, ".c"},         {31'd0, s1_ccc},       {31'd0, c});
    chk({tag, ".ovf"},       {31'd0, s1_ovf},       {31'd0, ovf});
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".hs_in_ready"},  {31'd0, s1_in_ready},  32'd1);
    chk({tag, ".hs_out_valid"}, {31'd0, s1_out_valid}, 32'd0);
    chk({tag, ".hs_cleared"},   {24'd0, s1_out_data},  32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst.in_ready",  {31'd0, s1_in_ready},  32'd1);
    chk("rst.out_valid", {31'd0, s1_out_valid}, 32'd0);
    chk("rst.out_data",  {24'd0, s1_out_data},  32'd0);
    chk("rst.cc", {28'd0, s1_ccn, s1_ccz, s1_ccc, s1_ovf}, 32'd0);
    step();
    step();
    reset = 1'b0;

    // Basic sum: 10+20+30+(-5) = 0x37 with carry out of the last add
    send(1'b0, 8'd10);
    send(1'b0, 8'd20);
    send(1'b0, 8'd30);
    chk("basic.no_valid_yet", {31'd0, s1_out_valid}, 32'd0);
    chk("basic.acc3",         {24'd0, s1_out_data},  32'h3C);
    send(1'b0, 8'hFB);
    chk_frame("basic", 8'h37, 1'b0, 1'b0, 1'b1, 1'b0);
    handshake("basic");

    // Positive overflow: saturating instance clamps, wrapping instance wraps
    send(1'b0, 8'd100);
    send(1'b0, 8'd100);
    chk("psat.acc2_sat",  {24'd0, s1_out_data}, 32'h7F);
    chk("psat.acc2_wrap", {24'd0, s0_out_data}, 32'hC8);
    send(1'b1, 8'd27);
    send(1'b0, 8'd0);
    chk_frame("psat", 8'h64, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("psat.wrap_data", {24'd0, s0_out_data}, 32'hAD);
    chk("psat.wrap_ovf",  {31'd0, s0_ovf},      32'd1);
    handshake("psat");

    // Negative overflow clamps at 0x80 and stays there
    send(1'b1, 8'd100);
    send(1'b1, 8'd100);
    chk("nsat.acc2", {24'd0, s1_out_data}, 32'h80);
    send(1'b1, 8'd1);
    chk("nsat.acc3", {24'd0, s1_out_data}, 32'h80);
    send(1'b0, 8'd0);
    chk_frame("nsat", 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    handshake("nsat");

    // Zero result; carry from the subtract is overwritten by later adds
    send(1'b0, 8'd5);
    send(1'b1, 8'd5);
    chk("zero.c_after2", {31'd0, s1_ccc}, 32'd1);
    chk("zero.z_after2", {31'd0, s1_ccz}, 32'd1);
    send(1'b0, 8'd0);
    send(1'b0, 8'd0);
    chk_frame("zero", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    handshake("zero");

    // Backpressure: DONE holds steady and ignores in_valid
    send(1'b0, 8'd7);
    send(1'b0, 8'd7);
    send(1'b0, 8'd7);
    send(1'b0, 8'd7);
    chk_frame("bp", 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp.stall_valid", {31'd0, s1_out_valid}, 32'd1);
      chk("bp.stall_ready", {31'd0, s1_in_ready},  32'd0);
      chk("bp.stall_data",  {24'd0, s1_out_data},  32'h1C);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp.release_ready", {31'd0, s1_in_ready},  32'd1);
    chk("bp.release_valid", {31'd0, s1_out_valid}, 32'd0);
    chk("bp.no_accept",     {24'd0, s1_out_data},  32'd0);
    in_valid = 1'b0;
    in_data  = 8'd0;

    // Asynchronous reset mid-frame
    send(1'b0, 8'd1);
    send(1'b0, 8'd2);
    chk("arst.before", {24'd0, s1_out_data}, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.data",      {24'd0, s1_out_data},  32'd0);
    chk("arst.in_ready",  {31'd0, s1_in_ready},  32'd1);
    chk("arst.out_valid", {31'd0, s1_out_valid}, 32'd0);
    step();
    reset = 1'b0;
    send(1'b0, 8'd1);
    send(1'b0, 8'd2);
    send(1'b0, 8'd3);
    chk("arst.no_early_valid", {31'd0, s1_out_valid}, 32'd0);
    send(1'b0, 8'd4);
    chk_frame("arst", 8'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    handshake("arst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
